// File: rtl/updown_sweep_pkg.sv
// Shared types and default widths for the up/down sweep sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package updown_sweep_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_HOLD_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP   = 3'd1,
    ST_HOLD = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/updown_cnt.sv
// Up/down counter with synchronous clear and count enable.
// Latency: count changes on the edge after en/clr are sampled.
// Backpressure: none; clear wins over enable, the owner guarantees no wrap.
module updown_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;

  // Counter register: clear has priority, otherwise step in the requested direction.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= i_up ? (r_count + ONE) : (r_count - ONE);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: 0 -> limit, dwell hold+1 cycles, back to 0, pulse done.
// Latency: done rises 2*limit+hold+1 edges after the start-sampling edge.
// Backpressure: none; start/limit/hold ignored while busy. Option UPDOWN_SWEEP_REPEAT_EN adds rpt.
module updown_sweep_ctrl
  import updown_sweep_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HOLD_W = DEF_HOLD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  limit,
  input  logic [HOLD_W-1:0] hold,
`ifdef UPDOWN_SWEEP_REPEAT_EN
  input  logic              rpt,
`endif
  output logic [WIDTH-1:0]  count,
  output logic              up,
  output logic              busy,
  output logic              at_peak,
  output logic              done
);

  localparam logic [WIDTH-1:0]  ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [HOLD_W-1:0] ONE_H = {{(HOLD_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [WIDTH-1:0]  r_limit;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] r_dwell;
  logic              r_up;
  logic              r_busy;
  logic              r_at_peak;
  logic              r_done;

  logic [WIDTH-1:0]  w_count;
  logic              w_cnt_en;
  logic              w_cnt_up;
  logic              w_cnt_clr;
  logic              w_at_top;
  logic              w_at_one;

  // Counter controls are decoded from the state register; abort clears the count
  // on the same edge the FSM returns to IDLE.
  assign w_cnt_en  = (r_state == ST_UP) || (r_state == ST_DOWN);
  assign w_cnt_up  = (r_state == ST_UP);
  assign w_cnt_clr = abort && (r_state != ST_IDLE);

  // Peak is reached when the increment about to happen lands on the latched limit;
  // the floor is reached when the decrement about to happen lands on zero.
  assign w_at_top = ((w_count + ONE_W) == r_limit);
  assign w_at_one = (w_count == ONE_W);

  updown_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_up    (w_cnt_up),
    .o_count (w_count)
  );

  // Sweep FSM with dwell counter, start-time latches and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_limit   <= '0;
      r_hold    <= '0;
      r_dwell   <= '0;
      r_up      <= 1'b1;
      r_busy    <= 1'b0;
      r_at_peak <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Pulse-style outputs default low; each branch re-asserts what it needs.
      r_done    <= 1'b0;
      r_at_peak <= 1'b0;
      if (abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_up    <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_limit <= limit;
              r_hold  <= hold;
              if (limit != '0) begin
                r_state <= ST_UP;
                r_busy  <= 1'b1;
              end else begin
                // Zero-height sweep: report completion without ever going busy.
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          ST_UP: begin
            if (w_at_top) begin
              r_state   <= ST_HOLD;
              r_dwell   <= r_hold;
              r_at_peak <= 1'b1;
            end
          end
          ST_HOLD: begin
            // Dwell counts hold..0, giving hold+1 cycles at the peak.
            if (r_dwell == '0) begin
              r_state <= ST_DOWN;
              r_up    <= 1'b0;
            end else begin
              r_dwell   <= r_dwell - ONE_H;
              r_at_peak <= 1'b1;
            end
          end
          ST_DOWN: begin
            if (w_at_one) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_up    <= 1'b1;
`ifdef UPDOWN_SWEEP_REPEAT_EN
              // Keep busy through DONE when another sweep is being requested.
              r_busy  <= rpt;
`else
              r_busy  <= 1'b0;
`endif
            end
          end
          ST_DONE: begin
`ifdef UPDOWN_SWEEP_REPEAT_EN
            if (rpt) begin
              r_limit <= limit;
              r_hold  <= hold;
              if (limit != '0) begin
                r_state <= ST_UP;
                r_busy  <= 1'b1;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
`else
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
`endif
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_up    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign count   = w_count;
  assign up      = r_up;
  assign busy    = r_busy;
  assign at_peak = r_at_peak;
  assign done    = r_done;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with hand-computed per-edge expectations.
// Edge 0 is the edge that samples start; checks are taken 1 time unit after each edge.
// Repeat scenario is compiled in only when UPDOWN_SWEEP_REPEAT_EN is defined.
module tb_updown_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] limit;
  logic [3:0] hold;
`ifdef UPDOWN_SWEEP_REPEAT_EN
  logic       rpt;
`endif
  logic [3:0] count;
  logic       up;
  logic       busy;
  logic       at_peak;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  // Hand-derived expectations for limit=3, hold=0 on edges 1..7.
  logic [3:0] exp_cnt3 [1:7] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd2, 4'd1, 4'd0};
  logic [7:1] exp_pk3   = 7'b0000100;
  logic [7:1] exp_dn3   = 7'b1000000;
  logic [7:1] exp_up3   = 7'b1000111;
  logic [7:1] exp_busy3 = 7'b0111111;

  updown_sweep_ctrl #(
    .WIDTH  (4),
    .HOLD_W (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .limit   (limit),
    .hold    (hold),
`ifdef UPDOWN_SWEEP_REPEAT_EN
    .rpt     (rpt),
`endif
    .count   (count),
    .up      (up),
    .busy    (busy),
    .at_peak (at_peak),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle start; returns 1 unit after the sampling edge (edge 0).
  task automatic start_sweep(input logic [3:0] l, input logic [3:0] h);
    start = 1'b1;
    limit = l;
    hold  = h;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int   n_done;
    int   n_peak;
    logic [3:0] e_cnt;

    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    limit = 4'd0;
    hold  = 4'd0;
`ifdef UPDOWN_SWEEP_REPEAT_EN
    rpt   = 1'b0;
`endif
    #22;
    chk("rst_count", count, 0);
    chk("rst_up", up, 1);
    chk("rst_busy", busy, 0);
    chk("rst_peak", at_peak, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Basic sweep; limit/hold changes after the start edge must be ignored.
    start_sweep(4'd3, 4'd0);
    chk("b_e0_busy", busy, 1);
    chk("b_e0_cnt", count, 0);
    limit = 4'd9;
    hold  = 4'd5;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk($sformatf("b_cnt%0d", e), count, exp_cnt3[e]);
      chk($sformatf("b_pk%0d", e), at_peak, exp_pk3[e]);
      chk($sformatf("b_dn%0d", e), done, exp_dn3[e]);
      chk($sformatf("b_up%0d", e), up, exp_up3[e]);
      chk($sformatf("b_busy%0d", e), busy, exp_busy3[e]);
    end
    tick();
    chk("b_after_done", done, 0);
    chk("b_after_busy", busy, 0);

    // Full-scale sweep with a 3-cycle dwell; must peak at 15 with no wrap.
    start_sweep(4'd15, 4'd2);
    n_peak = 0;
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (e <= 15)      e_cnt = 4'(e);
      else if (e <= 18) e_cnt = 4'd15;
      else              e_cnt = 4'(33 - e);
      chk($sformatf("m_cnt%0d", e), count, e_cnt);
      chk($sformatf("m_dn%0d", e), done, (e == 33) ? 1 : 0);
      if (at_peak) n_peak++;
    end
    chk("m_peak_cycles", n_peak, 3);
    tick();

    // Zero limit: immediate done, never busy.
    start_sweep(4'd0, 4'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_cnt", count, 0);
    tick();
    chk("z_done_off", done, 0);
    chk("z_busy_off", busy, 0);

    // Start while busy is dropped; exactly one done at edge 11.
    start_sweep(4'd5, 4'd0);
    n_done = 0;
    for (int e = 1; e <= 14; e++) begin
      if (e == 3) begin
        start = 1'b1;
        limit = 4'd2;
      end
      tick();
      start = 1'b0;
      if (e == 5) chk("i_peak5", count, 5);
      if (e == 11) chk("i_done11", done, 1);
      if (done) n_done++;
    end
    chk("i_done_cnt", n_done, 1);

    // Abort in DOWN at count 4.
    start_sweep(4'd6, 4'd0);
    for (int e = 1; e <= 9; e++) tick();
    chk("a_cnt_pre", count, 4);
    chk("a_up_pre", up, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("a_cnt", count, 0);
    chk("a_busy", busy, 0);
    chk("a_done", done, 0);
    chk("a_up", up, 1);
    tick();
    chk("a_done_late", done, 0);
    chk("a_busy_late", busy, 0);

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1;
    start = 1'b1;
    limit = 4'd3;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("as_busy", busy, 0);
    tick();
    chk("as_cnt", count, 0);
    chk("as_busy2", busy, 0);

    // Asynchronous reset mid-UP at count 2.
    start_sweep(4'd5, 4'd0);
    tick();
    tick();
    chk("r_cnt_pre", count, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("r_cnt", count, 0);
    chk("r_busy", busy, 0);
    chk("r_up", up, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    chk("r_idle_busy", busy, 0);
    chk("r_idle_cnt", count, 0);
    start_sweep(4'd1, 4'd0);
    tick();
    chk("r_l1_cnt", count, 1);
    chk("r_l1_peak", at_peak, 1);
    tick();
    tick();
    chk("r_l1_done", done, 1);
    chk("r_l1_cnt0", count, 0);
    tick();

`ifdef UPDOWN_SWEEP_REPEAT_EN
    // Back-to-back sweeps: busy held, done at edges 5 and 11.
    rpt = 1'b1;
    start_sweep(4'd2, 4'd0);
    n_done = 0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e == 6) rpt = 1'b0;
      if (e <= 10) chk($sformatf("p_busy%0d", e), busy, 1);
      chk($sformatf("p_dn%0d", e), done, (e == 5 || e == 11) ? 1 : 0);
      if (done) n_done++;
    end
    chk("p_done_cnt", n_done, 2);
    tick();
    chk("p_busy_end", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Sequencer for the 4-bit up/down counter datapath. After a start request it drives the counter through one triangle sweep: count up from 0 to a programmed limit, dwell for a programmed number of cycles, count back down to 0, then pulse done. It sits between the control/register interface and the counter, and owns the counter's up/enable/clear controls.

Parameters:
WIDTH, 4, counter and limit width in bits
HOLD_W, 4, dwell-length field width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
start  input  1  sweep request, sampled only in IDLE
abort  input  1  synchronous abort, returns to IDLE
limit  input  WIDTH  sweep peak value, latched on accepted start
hold  input  HOLD_W  dwell length, latched on accepted start
count  output  WIDTH  current counter value
up  output  1  counting direction, 1 = up
busy  output  1  high from accepted start until DONE
at_peak  output  1  high while in HOLD
done  output  1  one-cycle pulse at end of sweep

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, up=1, busy=0, at_peak=0, done=0, latched limit/hold=0.
- States: IDLE, UP, HOLD, DOWN, DONE. All outputs are registered or decoded from the state register; no combinational path from inputs to outputs.
- IDLE: count held at 0.
  - start=1 and limit!=0: latch limit_q/hold_q; next state UP; busy=1 from the next cycle.
  - start=1 and limit==0: no sweep; next state DONE (done pulses, count stays 0).
- UP: count+1 each cycle, up=1. When count+1==limit_q, next state HOLD, so count==limit_q on the first HOLD cycle.
- HOLD: count frozen, at_peak=1. A dwell counter loads hold_q on entry. HOLD lasts hold_q+1 cycles, then next state DOWN with up=0.
- DOWN: count-1 each cycle. When count-1==0, next state DONE.
- DONE: exactly one cycle; done=1, busy=0, count=0; next state IDLE.
- Latency: from the start-sampling edge to done high is 2·limit + hold + 1 edges.
- Arithmetic: count never wraps. limit=2^WIDTH-1 is legal and peaks at all-ones. hold=2^HOLD_W-1 gives a 2^HOLD_W-cycle dwell.
- start while busy: ignored, not queued. limit/hold changes while busy: ignored.
- abort=1 in any non-IDLE state: next state IDLE, count=0, busy=0, no done pulse. abort has priority over all transitions. abort in IDLE wins over start.
- Reset asserted mid-sweep: immediate return to reset values. Sweep restarts only on a new start after rst releases.

Optional Feature:
Macro: UPDOWN_SWEEP_REPEAT_EN
- Defined: adds input port `rpt` (1 bit). In DONE with rpt=1 and abort=0, the block re-latches limit/hold. If the new limit!=0, next state is UP instead of IDLE, busy stays 1, and done still pulses once per sweep. If the new limit==0, it goes to DONE again.
- Not defined: no rpt port; DONE always returns to IDLE.

Decomposition:
- Shared package updown_sweep_pkg: state enum (IDLE, UP, HOLD, DOWN, DONE), default WIDTH/HOLD_W constants.
- Sub-module updown_cnt: up/down counter with async active-low reset, synchronous clear, enable, up input. The FSM drives en/up/clr.
- FSM, dwell counter and latches stay in the top module.

Test Plan:
- Reset: rst=0 mid-UP with count=2 -> count=0, busy=0 immediately. After release, idle until start.
- Basic sweep: limit=3, hold=0, start one cycle -> count 1,2,3(HOLD 1 cycle),3,2,1,0. done high on edge 7 for one cycle; at_peak high for 1 cycle.
- Dwell and max: limit=15, hold=2 -> count peaks at 15 without wrap; at_peak high 3 cycles; done at edge 33.
- Zero limit / ignored start: limit=0, start -> done on next edge, busy never 1. Then start during a limit=5 sweep -> no effect, single done.
- Abort: abort=1 in DOWN with count=4 -> next edge IDLE, count=0, no done. abort+start in IDLE -> stays IDLE.
- Repeat (macro defined): rpt=1, limit=2, hold=0 -> two back-to-back sweeps, busy continuously 1, two done pulses 6 cycles apart.
